// File: rtl/aes_ctrl_fsm_if.sv
// Handshake and control-strobe bundle between the host/datapath side and the AES-128 sequencer.
// The master side drives the host handshake and datapath flags; the slave is the sequencer.
interface aes_ctrl_fsm_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic abort;
  logic done;
  logic done10;
  logic dp_clr;
  logic load_in;
  logic load_key;
  logic load_r10;
  logic cnt_en;
  logic out_en;
  logic busy;
  logic err;

  modport master (
    output in_valid, out_ready, abort, done, done10,
    input  in_ready, out_valid, dp_clr, load_in, load_key, load_r10,
           cnt_en, out_en, busy, err
  );

  modport slave (
    input  in_valid, out_ready, abort, done, done10,
    output in_ready, out_valid, dp_clr, load_in, load_key, load_r10,
           cnt_en, out_en, busy, err
  );
endinterface

// File: rtl/aes_ctrl_fsm.sv
// Moore sequencer for a single-block AES-128 datapath: whitening load, full rounds,
// final round, result capture, host handshake, abort and round-counter watchdog.
module aes_ctrl_fsm #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input logic          clk,
  input logic          clr,
  aes_ctrl_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    CAPT  = 3'd4,
    OUTV  = 3'd5,
    ERR   = 3'd6
  } state_t;

  // An inconsistent build configuration traps every block in ERR instead of running unchecked.
  localparam bit CFG_OK = (TIMEOUT > NR - 1) && (TIMEOUT <= (2 ** TW));

  // Output vector order: in_ready, out_valid, dp_clr, load_in, load_key,
  // load_r10, cnt_en, out_en, busy, err.
  localparam logic [9:0] OUT_IDLE  = 10'b1010000000;
  localparam logic [9:0] OUT_LOAD  = 10'b0001101010;
  localparam logic [9:0] OUT_ROUND = 10'b0000001010;
  localparam logic [9:0] OUT_FINAL = 10'b0000010010;
  localparam logic [9:0] OUT_CAPT  = 10'b0000000110;
  localparam logic [9:0] OUT_OUTV  = 10'b0100000000;
  localparam logic [9:0] OUT_ERR   = 10'b0010000001;

  state_t          state_r;
  state_t          next_s;
  logic [TW-1:0]   wd_r;
  logic            wd_hit_s;
  logic [9:0]      out_r;

  function automatic logic [9:0] decode(input state_t st);
    logic [9:0] v;
    case (st)
      IDLE:    v = OUT_IDLE;
      LOAD:    v = OUT_LOAD;
      ROUND:   v = OUT_ROUND;
      FINAL:   v = OUT_FINAL;
      CAPT:    v = OUT_CAPT;
      OUTV:    v = OUT_OUTV;
      ERR:     v = OUT_ERR;
      default: v = OUT_ERR;
    endcase
    return v;
  endfunction

  assign wd_hit_s = CFG_OK ? (wd_r == TW'(TIMEOUT - 1)) : 1'b1;

  // Next-state selection; abort outranks every transition except the IDLE handshake.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) next_s = LOAD;
        else              next_s = IDLE;
      end
      LOAD: begin
        if (bus.abort) next_s = IDLE;
        else           next_s = ROUND;
      end
      ROUND: begin
        if (bus.abort)       next_s = IDLE;
        else if (bus.done10) next_s = FINAL;
        else if (bus.done)   next_s = ERR;
        else if (wd_hit_s)   next_s = ERR;
        else                 next_s = ROUND;
      end
      FINAL: begin
        if (bus.abort) next_s = IDLE;
        else           next_s = CAPT;
      end
      CAPT: begin
        if (bus.abort) next_s = IDLE;
        else           next_s = OUTV;
      end
      OUTV: begin
        if (bus.abort)          next_s = IDLE;
        else if (bus.out_ready) next_s = IDLE;
        else                    next_s = OUTV;
      end
      ERR: begin
        if (bus.abort) next_s = IDLE;
        else           next_s = ERR;
      end
      default: next_s = ERR;
    endcase
  end

  // State register and state-decoded output register, updated together so outputs track state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      out_r   <= OUT_IDLE;
    end else begin
      state_r <= next_s;
      out_r   <= decode(next_s);
    end
  end

  // Watchdog counts consecutive ROUND cycles and is cleared everywhere else.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wd_r <= {TW{1'b0}};
    end else if (state_r == ROUND && next_s == ROUND) begin
      wd_r <= wd_r + TW'(1);
    end else begin
      wd_r <= {TW{1'b0}};
    end
  end

  assign bus.in_ready  = out_r[9];
  assign bus.out_valid = out_r[8];
  assign bus.dp_clr    = out_r[7];
  assign bus.load_in   = out_r[6];
  assign bus.load_key  = out_r[5];
  assign bus.load_r10  = out_r[4];
  assign bus.cnt_en    = out_r[3];
  assign bus.out_en    = out_r[2];
  assign bus.busy      = out_r[1];
  assign bus.err       = out_r[0];

endmodule

// File: tb/tb_aes_ctrl_fsm.sv
// Directed bench for aes_ctrl_fsm: nominal block, backpressure, watchdog, early terminal,
// abort, done10/timeout collision and asynchronous reset mid-block.
module tb_aes_ctrl_fsm;

  localparam logic [9:0] E_IDLE  = 10'b1010000000;
  localparam logic [9:0] E_LOAD  = 10'b0001101010;
  localparam logic [9:0] E_ROUND = 10'b0000001010;
  localparam logic [9:0] E_FINAL = 10'b0000010010;
  localparam logic [9:0] E_CAPT  = 10'b0000000110;
  localparam logic [9:0] E_OUTV  = 10'b0100000000;
  localparam logic [9:0] E_ERR   = 10'b0010000001;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_fail;

  aes_ctrl_fsm_if bus ();

  aes_ctrl_fsm #(.NR(10), .TIMEOUT(16), .TW(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] observed();
    return {bus.in_ready, bus.out_valid, bus.dp_clr, bus.load_in, bus.load_key,
            bus.load_r10, bus.cnt_en, bus.out_en, bus.busy, bus.err};
  endfunction

  task automatic check_outs(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    logic       onehot_ok;
    obs = observed();
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: outputs observed %b expected %b", tag, obs, exp);
    end
    onehot_ok = ($countones({obs[6], obs[4], obs[2]}) <= 1) && !(obs[2] && obs[3]);
    n_checks++;
    assert (onehot_ok === 1'b1)
    else begin
      n_fail++;
      $error("FAIL %s_onehot: strobes observed %b expected legal combination", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check_outs(tag, E_LOAD);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    clr           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.abort     = 1'b0;
    bus.done      = 1'b0;
    bus.done10    = 1'b0;
    #3;
    check_outs("reset", E_IDLE);
    #5 clr = 1'b0;
    step();
    check_outs("idle_after_reset", E_IDLE);

    // Nominal block: done10 raised during the 9th ROUND cycle
    accept("nom_load");
    for (int i = 1; i <= 9; i++) begin
      step();
      check_outs($sformatf("nom_round%0d", i), E_ROUND);
      if (i == 9) bus.done10 = 1'b1;
    end
    step();
    bus.done10 = 1'b0;
    check_outs("nom_final", E_FINAL);
    step();
    check_outs("nom_capt", E_CAPT);
    step();
    check_outs("nom_outv", E_OUTV);

    // Backpressure: out_valid held, no second out_en
    for (int i = 0; i < 20; i++) begin
      step();
      check_outs($sformatf("bp_hold%0d", i), E_OUTV);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_outs("bp_release_idle", E_IDLE);

    // Watchdog: done10 never asserted
    accept("wd_load");
    for (int i = 1; i <= 16; i++) begin
      step();
      check_outs($sformatf("wd_round%0d", i), E_ROUND);
    end
    step();
    check_outs("wd_err", E_ERR);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check_outs("wd_err_sticky", E_ERR);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_outs("wd_abort_idle", E_IDLE);

    // Early terminal: done without done10 at the 5th ROUND cycle
    accept("early_load");
    for (int i = 1; i <= 5; i++) begin
      step();
      check_outs($sformatf("early_round%0d", i), E_ROUND);
      if (i == 5) bus.done = 1'b1;
    end
    step();
    bus.done = 1'b0;
    check_outs("early_err", E_ERR);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_outs("early_abort_idle", E_IDLE);

    // Abort at the 4th ROUND cycle
    accept("abort_load");
    for (int i = 1; i <= 4; i++) begin
      step();
      check_outs($sformatf("abort_round%0d", i), E_ROUND);
      if (i == 4) bus.abort = 1'b1;
    end
    step();
    bus.abort = 1'b0;
    check_outs("abort_idle", E_IDLE);
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs($sformatf("abort_no_outen%0d", i), E_IDLE);
    end

    // done10 and timeout on the same edge: done10 wins
    accept("coll_load");
    for (int i = 1; i <= 16; i++) begin
      step();
      check_outs($sformatf("coll_round%0d", i), E_ROUND);
      if (i == 16) bus.done10 = 1'b1;
    end
    step();
    bus.done10 = 1'b0;
    check_outs("coll_final", E_FINAL);
    step();
    check_outs("coll_capt", E_CAPT);
    bus.out_ready = 1'b1;
    step();
    check_outs("coll_outv", E_OUTV);
    step();
    bus.out_ready = 1'b0;
    check_outs("coll_idle", E_IDLE);

    // abort in IDLE does not block the handshake; abort in LOAD returns to IDLE
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check_outs("idle_abort_load", E_LOAD);
    step();
    bus.abort = 1'b0;
    check_outs("load_abort_idle", E_IDLE);

    // Asynchronous reset in the middle of FINAL
    accept("rst_load");
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 9) bus.done10 = 1'b1;
    end
    step();
    bus.done10 = 1'b0;
    check_outs("rst_final", E_FINAL);
    clr = 1'b1;
    #1;
    check_outs("rst_async_now", E_IDLE);
    #2 clr = 1'b0;
    step();
    check_outs("rst_held_idle0", E_IDLE);
    step();
    check_outs("rst_held_idle1", E_IDLE);
    accept("rst_recover_load");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
